seg_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_scan_timer.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types, constants and the leading-zero blanking helper for the scan controller.
package seg_pkg;

  localparam logic [3:0]  BLANK_CODE = 4'hF;
  localparam int unsigned MAX_DIGITS = 8;

  typedef enum logic {
    DEAD  = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Replace every zero digit above the highest nonzero one (among the low n digits) with
  // BLANK_CODE. Digit 0 is never touched, so an all-zero value still shows "0".
  function automatic logic [31:0] lz_blank(input logic [31:0] digits, input int unsigned n);
    logic [31:0] res;
    logic        seen;
    res  = digits;
    seen = 1'b0;
    for (int unsigned i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < n) begin
        if (!seen && (digits[4*i +: 4] == 4'h0)) begin
          res[4*i +: 4] = BLANK_CODE;
        end else begin
          seen = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Phase timer: counts cycles spent in the current DEAD/DRIVE phase and flags the last one.
module seg_scan_timer #(
  parameter int unsigned CLK_DIV  = 50000,
  parameter int unsigned DEAD_CYC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic drive_i,
  output logic tc_c_o
);

  localparam int unsigned MAX_CYC = (CLK_DIV > DEAD_CYC) ? CLK_DIV : DEAD_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last_c;

  // Terminal count depends on which phase the controller is currently in.
  always_comb begin
    last_c = drive_i ? CW'(CLK_DIV - 1) : CW'(DEAD_CYC - 1);
    tc_c_o = (cnt_q == last_c);
    cnt_d  = (clear_i || tc_c_o) ? '0 : cnt_q + CW'(1);
  end

  // Cycle counter register; a terminal count starts the next phase from zero.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with dead-time blanking and frame-aligned commits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned DEAD_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] digits_in_i,
  input  logic                    blank_lz_i,
  output logic [3:0]              bcd_out_o,
  output logic [NUM_DIGITS-1:0]   an_out_o,
  output logic                    pending_o,
  output logic                    frame_tick_o
);

  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_t           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [DW-1:0]         active_q, active_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            bcd_q, bcd_d;
  logic                  tick_q, tick_d;
  logic                  commit_c;
  logic                  tc_c;
  logic [31:0]           lz_full_c;
  logic [DW-1:0]         blanked_c;

  seg_scan_timer #(
    .CLK_DIV  (CLK_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (!enable_i),
    .drive_i (state_q == DRIVE),
    .tc_c_o  (tc_c)
  );

  // Shadow value as it would be displayed, with optional leading-zero blanking.
  always_comb begin
    lz_full_c = lz_blank(32'(shadow_q), NUM_DIGITS);
    blanked_c = blank_lz_i ? lz_full_c[DW-1:0] : shadow_q;
  end

  // Next-state, buffer and output logic; outputs are decoded from the next state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    commit_c  = 1'b0;
    active_d  = active_q;
    shadow_d  = load_i ? digits_in_i : shadow_q;
    an_d      = '1;
    bcd_d     = BLANK_CODE;

    if (!enable_i) begin
      state_d = DEAD;
      idx_d   = '0;
    end else begin
      case (state_q)
        DEAD: begin
          if (tc_c) begin
            state_d  = DRIVE;
            commit_c = (idx_q == '0);
          end
        end
        DRIVE: begin
          if (tc_c) begin
            state_d = DEAD;
            idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
          end
        end
        default: state_d = DEAD;
      endcase
    end

    if (commit_c && pending_q) active_d = blanked_c;
    // A load in the commit slot wins, so its value waits for the next frame.
    pending_d = load_i ? 1'b1 : (commit_c ? 1'b0 : pending_q);
    tick_d    = commit_c;

    if (state_d == DRIVE) begin
      an_d[idx_d] = 1'b0;
      bcd_d       = active_d[4*idx_d +: 4];
    end
  end

  // State, buffer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= DEAD;
      idx_q     <= '0;
      shadow_q  <= '0;
      active_q  <= {NUM_DIGITS{BLANK_CODE}};
      pending_q <= 1'b0;
      an_q      <= '1;
      bcd_q     <= BLANK_CODE;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      bcd_q     <= bcd_d;
      tick_q    <= tick_d;
    end
  end

  assign bcd_out_o    = bcd_q;
  assign an_out_o     = an_q;
  assign pending_o    = pending_q;
  assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, CLK_DIV=4, DEAD_CYC=1).
module tb_seg_scan_ctrl;

  localparam int unsigned ND    = 4;
  localparam int unsigned DIGP  = 5;          // CLK_DIV + DEAD_CYC
  localparam int unsigned FRAME = ND * DIGP;

  logic        clk = 1'b0;
  logic        reset, enable, load, blank_lz;
  logic [15:0] digits_in;
  logic [3:0]  bcd_out;
  logic [3:0]  an_out;
  logic        pending, frame_tick;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_k;
  logic [15:0] m_shadow;
  logic        m_pending;
  logic [3:0]  m_active [ND];
  logic [3:0]  m_an, m_bcd;
  logic        m_tick;
  logic        cur_blz;

  typedef struct {
    logic [15:0] din;
    logic        blz;
    logic [15:0] exp;   // expected displayed digits, digit 0 in [3:0]
  } vec_t;
  vec_t vt [7];

  seg_scan_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(4), .DEAD_CYC(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_i     (enable),
    .load_i       (load),
    .digits_in_i  (digits_in),
    .blank_lz_i   (blank_lz),
    .bcd_out_o    (bcd_out),
    .an_out_o     (an_out),
    .pending_o    (pending),
    .frame_tick_o (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: position in the frame is derived from the count of enabled edges since a fresh start.
  task automatic model_edge(input logic rst, input logic en, input logic ld,
                            input logic [15:0] din, input logic blz);
    int   m;
    int   h;
    logic commit;
    if (rst) begin
      m_k = 0; m_shadow = '0; m_pending = 1'b0; m_tick = 1'b0;
      for (int d = 0; d < ND; d++) m_active[d] = 4'hF;
      m_an = 4'hF; m_bcd = 4'hF;
    end else begin
      commit = 1'b0;
      m = 0;
      if (!en) m_k = 0;
      else begin
        m_k++;
        m = (m_k - 1) % FRAME;
        commit = (m == 0);
      end
      if (commit && m_pending) begin
        h = -1;
        for (int d = 0; d < ND; d++) if (m_shadow[4*d +: 4] != 4'h0) h = d;
        for (int d = 0; d < ND; d++)
          m_active[d] = (blz && d > h && d > 0) ? 4'hF : m_shadow[4*d +: 4];
      end
      m_pending = ld ? 1'b1 : (commit ? 1'b0 : m_pending);
      if (ld) m_shadow = din;
      m_tick = commit;
      if (en && (m % DIGP) != DIGP - 1) begin
        m_an  = ~(4'b0001 << (m / DIGP));
        m_bcd = m_active[m / DIGP];
      end else begin
        m_an  = 4'hF;
        m_bcd = 4'hF;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, and compare all outputs against it.
  task automatic step(input logic rst, input logic en, input logic ld,
                      input logic [15:0] din, input logic blz);
    reset = rst; enable = en; load = ld; digits_in = din; blank_lz = blz;
    @(posedge clk);
    model_edge(rst, en, ld, din, blz);
    #1;
    check("an_out",     32'(an_out),     32'(m_an));
    check("bcd_out",    32'(bcd_out),    32'(m_bcd));
    check("pending",    32'(pending),    32'(m_pending));
    check("frame_tick", 32'(frame_tick), 32'(m_tick));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 16'h0, cur_blz);
  endtask

  task automatic wait_tick(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0, cur_blz);
      got = (frame_tick === 1'b1);
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s: frame_tick got 0 within %0d cycles, expected 1", nm, 2 * FRAME);
    end
  endtask

  // Record which code each digit shows over one frame, starting at the current tick sample.
  task automatic capture(output logic [15:0] seen);
    seen = 'x;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) step(1'b0, 1'b1, 1'b0, 16'h0, cur_blz);
      for (int d = 0; d < ND; d++)
        if (an_out == ~(4'b0001 << d)) seen[4*d +: 4] = bcd_out;
    end
  endtask

  initial begin
    logic [15:0] seen;
    int          ticks;
    bit          lit;

    vt[0] = '{16'h1234, 1'b0, 16'h1234};
    vt[1] = '{16'h0042, 1'b1, 16'hFF42};
    vt[2] = '{16'h0000, 1'b1, 16'hFFF0};
    vt[3] = '{16'h00A0, 1'b1, 16'hFFA0};
    vt[4] = '{16'h1000, 1'b1, 16'h1000};
    vt[5] = '{16'h0042, 1'b0, 16'h0042};
    vt[6] = '{16'h0305, 1'b1, 16'hF305};
    cur_blz = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check("rst_an", 32'(an_out), 32'hF);
    check("rst_bcd", 32'(bcd_out), 32'hF);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_tick", 32'(frame_tick), 32'h0);

    // Idle scan with no load: dark digits, tick every frame
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("first_drive_an", 32'(an_out), 32'hE);
    check("first_tick", 32'(frame_tick), 32'h1);
    ticks = 1; lit = 1'b0;
    for (int i = 1; i < 2 * FRAME; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      if (frame_tick) ticks++;
      if (bcd_out != 4'hF) lit = 1'b1;
    end
    check("idle_ticks", 32'(ticks), 32'd2);
    check("idle_dark", 32'(lit), 32'h0);

    // Table-driven display values
    foreach (vt[v]) begin
      wait_tick("pre_load_tick");
      cur_blz = vt[v].blz;
      step(1'b0, 1'b1, 1'b1, vt[v].din, cur_blz);
      check("load_pending", 32'(pending), 32'h1);
      wait_tick("commit_tick");
      check("commit_pending", 32'(pending), 32'h0);
      capture(seen);
      for (int d = 0; d < ND; d++)
        check($sformatf("vec%0d_digit%0d", v, d), 32'(seen[4*d +: 4]), 32'(vt[v].exp[4*d +: 4]));
    end

    // Load coinciding with the commit slot: old value stays, new one commits next frame
    step(1'b0, 1'b1, 1'b1, 16'h5678, 1'b0);
    check("slot_tick", 32'(frame_tick), 32'h1);
    check("slot_pending", 32'(pending), 32'h1);
    check("slot_old_digit0", 32'(bcd_out), 32'h5);
    cur_blz = 1'b0;
    wait_tick("slot_next_tick");
    check("slot_next_pending", 32'(pending), 32'h0);
    capture(seen);
    check("slot_next_frame", 32'(seen), 32'h5678);

    // Enable dropped mid-DRIVE of digit 2, then re-enabled
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("en_frame_tick", 32'(frame_tick), 32'h1);
    idle(11);
    check("en_digit2_an", 32'(an_out), 32'hB);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("dis_an", 32'(an_out), 32'hF);
    check("dis_bcd", 32'(bcd_out), 32'hF);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("reen_tick", 32'(frame_tick), 32'h1);
    check("reen_an", 32'(an_out), 32'hE);
    check("reen_bcd", 32'(bcd_out), 32'h8);

    // Reset mid-frame with pending data
    step(1'b0, 1'b1, 1'b1, 16'h9999, 1'b0);
    idle(5);
    check("pre_rst_pending", 32'(pending), 32'h1);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    check("mid_rst_an", 32'(an_out), 32'hF);
    check("mid_rst_bcd", 32'(bcd_out), 32'hF);
    check("mid_rst_pending", 32'(pending), 32'h0);
    check("mid_rst_tick", 32'(frame_tick), 32'h0);
    ticks = 0; lit = 1'b0;
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      if (frame_tick) ticks++;
      if (bcd_out != 4'hF) lit = 1'b1;
    end
    check("post_rst_ticks", 32'(ticks), 32'd3);
    check("post_rst_dark", 32'(lit), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] din;
      for (int d = 0; d < ND; d++)
        din[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 9) == 0), din, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
